// File: rtl/ma_stage_ctrl_pkg.sv
// ma_stage_ctrl_pkg: shared definitions for the memory-access stage controller.
//   - Access size encodings (SZ_BYTE, SZ_HALF, SZ_WORD; encoding 3 behaves as word).
//   - FSM state enum (IDLE, REQ, RESP, DONE).
//   - is_misaligned(): alignment rule shared by the stage and its aligner.
package ma_stage_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_e;

    // Halves need addr[0] clear; words (and the illegal size) need addr[1:0] clear.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ma_align.sv
// ma_align: purely combinational lane logic for sub-word memory accesses.
// Ports:
//   i_size     access size (SZ_BYTE / SZ_HALF / SZ_WORD, 3 treated as word)
//   i_lane     byte lane within the data word (low address bits)
//   i_unsigned zero-extend instead of sign-extend loaded data
//   i_wdata    right-aligned store data
//   i_rdata    raw memory read data
//   o_be       byte enables for the addressed lanes
//   o_wdata    store data replicated into every lane group
//   o_rdata    extracted and extended load data
//   o_misalign access violates natural alignment
module ma_align
    import ma_stage_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]                    i_size,
    input  logic [$clog2(DATA_W/8)-1:0]   i_lane,
    input  logic                          i_unsigned,
    input  logic [DATA_W-1:0]             i_wdata,
    input  logic [DATA_W-1:0]             i_rdata,
    output logic [DATA_W/8-1:0]           o_be,
    output logic [DATA_W-1:0]             o_wdata,
    output logic [DATA_W-1:0]             o_rdata,
    output logic                          o_misalign
);

    localparam int NB     = DATA_W / 8;
    localparam int LANE_W = $clog2(NB);

    logic [LANE_W+2:0] w_bit_off;
    logic [15:0]       w_low16;

    assign w_bit_off = {i_lane, 3'b000};
    // Only the low 16 bits of the shifted word are ever needed.
    assign w_low16   = 16'(i_rdata >> w_bit_off);

    always_comb begin
        o_be    = '1;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
        case (i_size)
            SZ_BYTE: begin
                o_be    = NB'(1) << i_lane;
                o_wdata = {NB{i_wdata[7:0]}};
                o_rdata = i_unsigned ? {{(DATA_W-8){1'b0}}, w_low16[7:0]}
                                     : {{(DATA_W-8){w_low16[7]}}, w_low16[7:0]};
            end
            SZ_HALF: begin
                o_be    = NB'(3) << i_lane;
                o_wdata = {(NB/2){i_wdata[15:0]}};
                o_rdata = i_unsigned ? {{(DATA_W-16){1'b0}}, w_low16}
                                     : {{(DATA_W-16){w_low16[15]}}, w_low16};
            end
            default: begin
                o_be    = '1;
                o_wdata = i_wdata;
                o_rdata = i_rdata;
            end
        endcase
    end

    assign o_misalign = is_misaligned(i_size, 2'(i_lane));

endmodule

// File: rtl/ma_stage_ctrl.sv
// ma_stage_ctrl: clocked, back-pressured memory-access stage between execute and writeback.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid / in_ready        operation handshake from execute
//   is_ld, is_st, size,
//   ld_unsigned, alu_result,
//   op2                        operation fields captured on accept
//   mem_req/we/addr/be/wdata   data-memory request (held stable until mem_gnt)
//   mem_gnt, mem_rvalid,
//   mem_rdata                  data-memory grant and response
//   out_valid / out_ready      result handshake to writeback
//   ld_result, misalign        result, held while out_valid is stalled
module ma_stage_ctrl
    import ma_stage_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 is_ld,
    input  logic                 is_st,
    input  logic [1:0]           size,
    input  logic                 ld_unsigned,
    input  logic [ADDR_W-1:0]    alu_result,
    input  logic [DATA_W-1:0]    op2,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W/8-1:0]  mem_be,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    ld_result,
    output logic                 misalign
);

    localparam int NB     = DATA_W / 8;
    localparam int LANE_W = $clog2(NB);

    state_e              r_state;
    state_e              w_state_next;
    logic                r_is_ld;
    logic                r_we;
    logic [1:0]          r_size;
    logic [LANE_W-1:0]   r_lane;
    logic                r_unsigned;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [NB-1:0]       r_mem_be;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_ld_result;
    logic                r_misalign;

    logic                w_accept;
    logic                w_ld_latch;
    logic                w_is_mem;
    logic [1:0]          w_sel_size;
    logic [LANE_W-1:0]   w_sel_lane;
    logic                w_sel_unsigned;
    logic [NB-1:0]       w_be;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_rdata;
    logic                w_align_mis;
    logic [DATA_W-1:0]   w_alu_ext;

    assign w_is_mem  = is_ld | is_st;
    assign w_alu_ext = DATA_W'(alu_result);
    assign w_accept  = (r_state == IDLE) && in_valid;

    // One aligner serves both directions: live inputs while idle (request side),
    // captured fields while waiting for read data (response side).
    assign w_sel_size     = (r_state == IDLE) ? size : r_size;
    assign w_sel_lane     = (r_state == IDLE) ? alu_result[LANE_W-1:0] : r_lane;
    assign w_sel_unsigned = (r_state == IDLE) ? ld_unsigned : r_unsigned;

    ma_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .i_size     (w_sel_size),
        .i_lane     (w_sel_lane),
        .i_unsigned (w_sel_unsigned),
        .i_wdata    (op2),
        .i_rdata    (mem_rdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_rdata    (w_rdata),
        .o_misalign (w_align_mis)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ld_latch   = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Misaligned accesses skip memory entirely.
                    w_state_next = (w_is_mem && !w_align_mis) ? REQ : DONE;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                mem_we  = r_we;
                if (mem_gnt) begin
                    if (!r_is_ld) begin
                        w_state_next = DONE;
                    end else if (mem_rvalid) begin
                        w_state_next = DONE;
                        w_ld_latch   = 1'b1;
                    end else begin
                        w_state_next = RESP;
                    end
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    w_state_next = DONE;
                    w_ld_latch   = 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_is_ld     <= 1'b0;
            r_we        <= 1'b0;
            r_size      <= SZ_BYTE;
            r_lane      <= '0;
            r_unsigned  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_ld_result <= '0;
            r_misalign  <= 1'b0;
        end else if (w_accept) begin
            r_is_ld     <= is_ld;
            r_we        <= is_st && !is_ld;
            r_size      <= size;
            r_lane      <= alu_result[LANE_W-1:0];
            r_unsigned  <= ld_unsigned;
            r_mem_addr  <= {alu_result[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
            r_mem_be    <= w_be;
            r_mem_wdata <= w_wdata;
            // Loads overwrite this when data returns; everything else reports the address.
            r_ld_result <= w_alu_ext;
            r_misalign  <= w_is_mem && w_align_mis;
        end else if (w_ld_latch) begin
            r_ld_result <= w_rdata;
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;
    assign ld_result = r_ld_result;
    assign misalign  = r_misalign;

endmodule

// File: tb/tb_ma_stage_ctrl.sv
// tb_ma_stage_ctrl: directed and randomized checks of ma_stage_ctrl (DATA_W = ADDR_W = 32)
// against an arithmetic reference model of the access rules.
module tb_ma_stage_ctrl;
    import ma_stage_ctrl_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid, in_ready;
    logic              is_ld, is_st;
    logic [1:0]        size;
    logic              ld_unsigned;
    logic [ADDR_W-1:0] alu_result;
    logic [DATA_W-1:0] op2;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt, mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid, out_ready;
    logic [DATA_W-1:0] ld_result;
    logic              misalign;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ma_stage_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .is_ld       (is_ld),
        .is_st       (is_st),
        .size        (size),
        .ld_unsigned (ld_unsigned),
        .alu_result  (alu_result),
        .op2         (op2),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ld_result   (ld_result),
        .misalign    (misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    // Load value: pick the addressed bytes and extend, using plain integer arithmetic.
    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] addr, input logic [31:0] rd);
        int     n;
        int     lane;
        longint v;
        n    = nbytes(sz);
        lane = int'(addr % 4);
        if (n == 4) return rd;
        v = longint'(rd / (32'd1 << (8 * lane))) % (longint'(1) << (8 * n));
        if (!uns && v >= (longint'(1) << (8 * n - 1)))
            v = v + (longint'(1) << 32) - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic run_op(input string tag, input logic ld, input logic st,
                          input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int g_in, input int r_in, input int od);
        int          n, lane, g, r, exp_done;
        logic        mis, memop, load;
        logic [31:0] exp_res, exp_be, exp_wd, exp_addr;
        logic        exp_we;

        n        = nbytes(sz);
        lane     = int'(addr % 4);
        mis      = (ld || st) && (addr % n != 0);
        memop    = (ld || st) && !mis;
        load     = ld && memop;
        g        = memop ? g_in : 0;
        r        = load ? r_in : 0;
        exp_done = !memop ? 1 : (load ? 2 + g + r : 2 + g);
        exp_res  = load ? ref_load(sz, uns, addr, rd) : addr;
        exp_be   = ((32'd1 << n) - 1) << lane;
        exp_wd   = 0;
        for (int i = 0; i < 4 / n; i++)
            exp_wd = exp_wd + ((wd % (33'd1 << (8 * n))) << (8 * n * i));
        exp_addr = addr - lane;
        exp_we   = st && !ld;

        @(negedge clk);
        chk({tag, "/in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid    = 1'b1;
        is_ld       = ld;
        is_st       = st;
        size        = sz;
        ld_unsigned = uns;
        alu_result  = addr;
        op2         = wd;
        @(posedge clk);
        #1;
        // Scramble the operation inputs: the stage must work from its captured copy.
        in_valid    = 1'($urandom);
        is_ld       = 1'($urandom);
        is_st       = 1'($urandom);
        size        = 2'($urandom);
        ld_unsigned = 1'($urandom);
        alu_result  = $urandom;
        op2         = $urandom;

        for (int c = 1; c <= exp_done + od; c++) begin
            mem_gnt    = memop ? (c == 1 + g) : 1'($urandom);
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (load && c == 1 + g + r) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd;
            end else if (!load || c < 1 + g || c > 1 + g + r) begin
                mem_rvalid = 1'($urandom);
            end
            out_ready = (c >= exp_done + od);
            @(negedge clk);
            chk({tag, "/in_ready_busy"}, 32'(in_ready), 32'd0);
            chk({tag, "/out_valid"}, 32'(out_valid), 32'(c >= exp_done));
            chk({tag, "/mem_req"}, 32'(mem_req), 32'(memop && c <= 1 + g));
            if (memop && c <= 1 + g) begin
                chk({tag, "/mem_we"}, 32'(mem_we), 32'(exp_we));
                chk({tag, "/mem_addr"}, mem_addr, exp_addr);
                chk({tag, "/mem_be"}, 32'(mem_be), exp_be);
                if (exp_we) chk({tag, "/mem_wdata"}, mem_wdata, exp_wd);
            end
            if (c >= exp_done) begin
                chk({tag, "/ld_result"}, ld_result, exp_res);
                chk({tag, "/misalign"}, 32'(misalign), 32'(mis));
            end
            @(posedge clk);
            #1;
        end
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        is_ld       = 1'b0;
        is_st       = 1'b0;
        size        = SZ_BYTE;
        ld_unsigned = 1'b0;
        alu_result  = '0;
        op2         = '0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        out_ready   = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst/in_ready", 32'(in_ready), 32'd1);
        chk("rst/out_valid", 32'(out_valid), 32'd0);
        chk("rst/mem_req", 32'(mem_req), 32'd0);
        chk("rst/mem_we", 32'(mem_we), 32'd0);
        chk("rst/misalign", 32'(misalign), 32'd0);
        chk("rst/ld_result", ld_result, 32'd0);
        chk("rst/mem_addr", mem_addr, 32'd0);
        chk("rst/mem_be", 32'(mem_be), 32'd0);
        chk("rst/mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;

        run_op("word_store", 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 0);
        run_op("ldb_signed", 1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h203, 32'h0, 32'h80FFFF12, 0, 0, 0);
        run_op("ldb_unsigned", 1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h203, 32'h0, 32'h80FFFF12, 0, 0, 0);
        run_op("ldh_delayed", 1'b1, 1'b0, SZ_HALF, 1'b0, 32'h302, 32'h0, 32'h7FFF0000, 3, 1, 0);
        run_op("mis_word_st", 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h101, 32'h12345678, 32'h0, 0, 0, 0);
        run_op("backpressure", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h500, 32'h0, 32'hCAFEF00D, 1, 0, 4);
        run_op("after_bp", 1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h602, 32'hA5, 32'h0, 0, 0, 0);
        run_op("non_mem", 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h13579BDF, 32'h0, 32'h0, 0, 0, 0);
        run_op("ld_and_st", 1'b1, 1'b1, SZ_HALF, 1'b1, 32'h206, 32'h1111, 32'h8001ABCD, 0, 2, 0);
        run_op("illegal_size", 1'b1, 1'b0, 2'd3, 1'b0, 32'h208, 32'h0, 32'h89ABCDEF, 2, 0, 0);
        run_op("mis_half_ld", 1'b1, 1'b0, SZ_HALF, 1'b0, 32'h207, 32'h0, 32'hFFFFFFFF, 0, 0, 1);

        for (int k = 0; k < 60; k++) begin
            run_op("rand", 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                   $urandom, $urandom, $urandom, int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        // Reset while waiting in RESP: transaction abandoned, late rvalid ignored.
        @(negedge clk);
        in_valid    = 1'b1;
        is_ld       = 1'b1;
        is_st       = 1'b0;
        size        = SZ_WORD;
        ld_unsigned = 1'b0;
        alu_result  = 32'h400;
        op2         = 32'h55AA55AA;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mem_gnt  = 1'b1;
        @(posedge clk);
        #1;
        mem_gnt = 1'b0;
        @(negedge clk);
        chk("resp/mem_req", 32'(mem_req), 32'd0);
        chk("resp/out_valid", 32'(out_valid), 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_mid/out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid/mem_req", 32'(mem_req), 32'd0);
        chk("rst_mid/mem_we", 32'(mem_we), 32'd0);
        chk("rst_mid/misalign", 32'(misalign), 32'd0);
        chk("rst_mid/ld_result", ld_result, 32'd0);
        chk("rst_mid/mem_addr", mem_addr, 32'd0);
        chk("rst_mid/mem_be", 32'(mem_be), 32'd0);
        chk("rst_mid/mem_wdata", mem_wdata, 32'd0);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0BAD0;
        out_ready  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("late_rvalid/out_valid", 32'(out_valid), 32'd0);
            chk("late_rvalid/mem_req", 32'(mem_req), 32'd0);
            chk("late_rvalid/in_ready", 32'(in_ready), 32'd1);
        end
        mem_rvalid = 1'b0;
        out_ready  = 1'b0;

        run_op("post_reset", 1'b1, 1'b0, SZ_HALF, 1'b0, 32'h402, 32'h0, 32'h8000FFFF, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
